key_event_gen: RTL

//   Producer of the one-cycle key events consumed by the vision-test state controller.

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_event_gen_if.sv | 28 ++
 rtl/key_debounce.sv | 111 +++++++++++
 rtl/key_event_gen.sv | 92 +++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the push-button event path.
//   - Key index positions within the 5-bit key vectors.
//   - Per-key debounce FSM state encoding.
package key_pkg;

  localparam int NUM_KEYS    = 5;
  localparam int KEY_RESTART = 0;
  localparam int KEY_LEFT    = 1;
  localparam int KEY_RIGHT   = 2;
  localparam int KEY_UP      = 3;
  localparam int KEY_DOWN    = 4;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

endpackage

// File: rtl/key_event_gen_if.sv
// Bundle between the board-pin side and the key event consumer.
//   key_raw      raw push-button levels [0]=restart [1]=left [2]=right [3]=up [4]=down
//   RESTARTdown  one-cycle press pulse, restart
//   LeftDown     one-cycle press pulse, left
//   RightDown    one-cycle press pulse, right
//   UpDown       one-cycle press pulse, up
//   DownDown     one-cycle press pulse, down
//   key_held     debounced pressed level per key, same bit order as key_raw
// master: drives key_raw, observes events. slave: the event generator.
interface key_event_gen_if;
  logic [4:0] key_raw;
  logic       RESTARTdown;
  logic       LeftDown;
  logic       RightDown;
  logic       UpDown;
  logic       DownDown;
  logic [4:0] key_held;

  modport master (
    output key_raw,
    input  RESTARTdown, LeftDown, RightDown, UpDown, DownDown, key_held
  );

  modport slave (
    input  key_raw,
    output RESTARTdown, LeftDown, RightDown, UpDown, DownDown, key_held
  );
endinterface

// File: rtl/key_debounce.sv
// One push-button channel: 2-FF synchroniser, polarity normalisation, stability
// counter and debounce FSM.
//   clk, rst    system clock, asynchronous active-high reset
//   key_raw_i   raw pin level
//   held_o      debounced pressed level (1 = pressed)
//   rise_o      strobe, high in the cycle before held_o rises (press qualifies)
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20000,
  parameter int CNT_W        = 15,
  parameter int ACTIVE_HIGH  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw_i,
  output logic held_o,
  output logic rise_o
);

  localparam logic             REL_LVL = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  logic             s1_q, s2_q;
  logic             sync;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done;

  // Synchroniser resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= REL_LVL;
      s2_q <= REL_LVL;
    end else begin
      s1_q <= key_raw_i;
      s2_q <= s1_q;
    end
  end

  assign sync = (ACTIVE_HIGH != 0) ? s2_q : ~s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The cycle that would bring the count to DEBOUNCE_CYC is the acceptance cycle.
  assign done = (sat_inc(cnt_q) == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_o  = 1'b0;
    case (state_q)
      RELEASED: begin
        if (sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (done) begin
          state_d = PRESSED;
          cnt_d   = '0;
          rise_o  = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (done) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // The debounced level is high in the states whose stable reference is "pressed".
  assign held_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/key_event_gen.sv
// Key event producer: debounces five raw buttons and emits registered one-cycle
// press pulses, arbitrating direction keys with a lockout until all directions
// are released. Restart is never arbitrated or locked.
//   clk, rst  system clock, asynchronous active-high reset
//   bus       key_event_gen_if.slave (key_raw in; pulses and key_held out)
// Build option: KEY_MULTI_REJECT_EN -- a direction press that overlaps any other
//   direction key (held or qualifying in the same cycle) issues no pulse and locks.
//   Undefined: same-cycle direction presses resolve Left > Right > Up > Down.
module key_event_gen
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20000,
  parameter int CNT_W        = 15,
  parameter int ACTIVE_HIGH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  key_event_gen_if.slave    bus
);

  logic [NUM_KEYS-1:0] held;
  logic [NUM_KEYS-1:0] rise;
  logic [3:0]          dir_rise, dir_held, dir_pulse_d, dir_pulse_q;
  logic                rst_pulse_q;
  logic                dir_lock_q, dir_lock_d;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W),
      .ACTIVE_HIGH  (ACTIVE_HIGH)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .key_raw_i (bus.key_raw[g]),
      .held_o    (held[g]),
      .rise_o    (rise[g])
    );
  end

  assign dir_rise = rise[KEY_DOWN:KEY_LEFT];
  assign dir_held = held[KEY_DOWN:KEY_LEFT];

`ifdef KEY_MULTI_REJECT_EN
  function automatic logic multi_bit(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction
`else
  // Lowest set bit wins: bit 0 of the direction vector is Left.
  function automatic logic [3:0] lowest_bit(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction
`endif

  always_comb begin
    dir_pulse_d = '0;
    dir_lock_d  = dir_lock_q;
    if ((dir_rise != '0) && !dir_lock_q) begin
`ifdef KEY_MULTI_REJECT_EN
      // A rising key's own held bit is still 0, so any held direction is "another" key.
      if (!multi_bit(dir_rise) && (dir_held == '0))
        dir_pulse_d = dir_rise;
`else
      dir_pulse_d = lowest_bit(dir_rise);
`endif
      dir_lock_d = 1'b1;
    end else if (dir_held == '0) begin
      dir_lock_d = 1'b0;
    end
  end

  // Output stage: pulses registered on the same edge the debounced level rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_pulse_q <= 1'b0;
      dir_pulse_q <= '0;
      dir_lock_q  <= 1'b0;
    end else begin
      rst_pulse_q <= rise[KEY_RESTART];
      dir_pulse_q <= dir_pulse_d;
      dir_lock_q  <= dir_lock_d;
    end
  end

  assign bus.RESTARTdown = rst_pulse_q;
  assign bus.LeftDown    = dir_pulse_q[0];
  assign bus.RightDown   = dir_pulse_q[1];
  assign bus.UpDown      = dir_pulse_q[2];
  assign bus.DownDown    = dir_pulse_q[3];
  assign bus.key_held    = held;

endmodule
